i_cache: RTL and testbench
==========================

Name: i_cache

Overview:
- Direct-mapped, read-only instruction cache between the CPU instruction-fetch port and instruction memory.
- Hits return the fetch word in the same cycle.
- Misses stall the CPU via c_ready while a whole line is fetched from memory over a request/valid handshake.
- Also provides a flush input and hit/miss counters for performance measurement.

Parameters:
- WORD_SIZE, 16, data and address width in bits.
- LINE_WORDS, 4, words per line (power of 2); OFS_W = log2(LINE_WORDS).
- NUM_LINES, 8, lines in the cache (power of 2); IDX_W = log2(NUM_LINES); TAG_W = WORD_SIZE - IDX_W - OFS_W.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- c_readM  input  1  CPU fetch request.
- c_address  input  WORD_SIZE  CPU fetch word address.
- c_data  output  WORD_SIZE  fetched instruction word; valid when c_ready=1.
- c_ready  output  1  data valid this cycle; CPU stalls fetch while c_readM=1 and c_ready=0.
- flush  input  1  invalidate all lines.
- m_readM  output  1  line-fill request to memory.
- m_address  output  WORD_SIZE  line-aligned fill address (low OFS_W bits zero).
- m_line  input  WORD_SIZE*LINE_WORDS  fill data; word k in bits [k*WORD_SIZE +: WORD_SIZE].
- m_valid  input  1  one-cycle pulse; m_line valid.
- num_hits  output  WORD_SIZE  hit counter.
- num_misses  output  WORD_SIZE  miss counter.

Behaviour:
- Address split: tag = c_address[WORD_SIZE-1 -: TAG_W], idx = next IDX_W bits, ofs = low OFS_W bits.
- Storage: valid[NUM_LINES], tag[NUM_LINES], data[NUM_LINES][LINE_WORDS].
- Reset:
  - state=IDLE; all valid bits=0; m_readM=0; m_address=0.
  - num_hits=0; num_misses=0; flush_pending=0.
  - Tag/data contents need not be cleared.
- hit = valid[idx] && tag[idx]==tag (combinational).
- FSM states: IDLE, FILL, RESP.
- IDLE:
  - c_ready = c_readM && hit, combinational (zero-latency hit).
  - c_data = data[idx][ofs] on a hit.
  - Each cycle with c_readM && hit: num_hits+1.
  - c_readM && !hit:
    - latch miss_addr = c_address;
    - num_misses+1;
    - next state FILL.
  - c_readM=0: c_ready=0 and no counting.
- FILL:
  - m_readM=1; m_address = {miss_addr[WORD_SIZE-1:OFS_W], OFS_W'b0}, held stable until m_valid.
  - c_ready=0.
  - On m_valid:
    - write data[midx] = m_line, tag[midx], and valid[midx]=1;
    - m_readM=0 from the next cycle;
    - next state RESP.
  - Memory latency is unbounded; there is no timeout.
- RESP (exactly 1 cycle):
  - If c_readM && c_address==miss_addr: c_ready=1 and c_data = m_line word miss_addr[ofs], from a registered copy of the line.
  - Otherwise c_ready=0.
  - The RESP cycle is not counted as a hit.
  - Next state IDLE.
- Request changed or withdrawn during FILL: the fill still completes and installs miss_addr's line. The new address is looked up normally in IDLE.
- Flush:
  - In IDLE: all valid bits cleared at the next edge. A lookup in the same cycle as flush still uses the pre-flush valid bits.
  - In FILL or RESP: sets flush_pending. When the FSM enters IDLE, all valid bits are cleared (including the just-filled line) and flush_pending is cleared.
- m_valid outside FILL is ignored.
- Reset mid-FILL: FSM returns to IDLE and m_readM=0 after the reset edge. A late m_valid is ignored and no line is installed.
- Counters wrap modulo 2^WORD_SIZE.
- Simultaneous reset and any other input: reset wins.

Decomposition:
- Shared package/include:
  - WORD_SIZE (existing `WORD_SIZE define);
  - FSM state encodings IC_IDLE / IC_FILL / IC_RESP as localparams or defines;
  - helper constants for OFS_W / IDX_W / TAG_W.
- One natural sub-module: ic_tag_store, holding the valid/tag arrays with lookup, install and flush-all.
- The data array and FSM stay in i_cache.

Test Plan:
- Reset, then c_readM=1, c_address=16'h0005 → miss:
  - FILL with m_address=16'h0004, m_readM=1;
  - m_valid after 3 cycles with words {A0,A1,A2,A3};
  - RESP c_data=A1, c_ready=1;
  - num_misses=1.
- Then read 16'h0004, 16'h0006, 16'h0007 → each hits same cycle with A0, A2, A3; num_hits=3; m_readM stays 0.
- Conflict: read 16'h0025 (same idx 1, tag differs) → miss and refill at m_address=16'h0024. Re-read 16'h0005 → miss again. num_misses=3.
- Flush asserted mid-FILL for 16'h0040:
  - fill completes and RESP returns data;
  - the next cycle all valid bits are 0;
  - reading 16'h0040 again misses.
- c_readM dropped during FILL → fill completes, RESP gives c_ready=0. A later read of the same address hits with no memory traffic.
- reset asserted during FILL → m_readM=0 next cycle; a late m_valid is ignored; counters=0; re-read misses.

Source files
------------

// File: rtl/i_cache_pkg.sv
// Shared constants and FSM encoding for the direct-mapped instruction cache.
// Default geometry: 16-bit words, 4-word lines, 8 lines.
package i_cache_pkg;
   localparam int IC_WORD_SIZE  = 16;
   localparam int IC_LINE_WORDS = 4;
   localparam int IC_NUM_LINES  = 8;
   localparam int IC_OFS_W      = $clog2(IC_LINE_WORDS);
   localparam int IC_IDX_W      = $clog2(IC_NUM_LINES);
   localparam int IC_TAG_W      = IC_WORD_SIZE - IC_IDX_W - IC_OFS_W;

   typedef enum logic [1:0] {
      IC_IDLE = 2'd0,
      IC_FILL = 2'd1,
      IC_RESP = 2'd2
   } ic_state_e;
endpackage

// File: rtl/ic_tag_store.sv
// Valid bits and tags for the direct-mapped cache.
// Provides a combinational lookup, a single-line install and a flush of every line.
module ic_tag_store
   import i_cache_pkg::*;
#(
   parameter int NUM_LINES = IC_NUM_LINES,
   parameter int IDX_W     = IC_IDX_W,
   parameter int TAG_W     = IC_TAG_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [IDX_W-1:0] i_lookup_idx,
   input  logic [TAG_W-1:0] i_lookup_tag,
   output logic             o_hit,
   input  logic             i_install,
   input  logic [IDX_W-1:0] i_install_idx,
   input  logic [TAG_W-1:0] i_install_tag,
   input  logic             i_flush_all
);
   logic [NUM_LINES-1:0] w_valid;
   logic [TAG_W-1:0]     r_tag [NUM_LINES];

   // Flush wins over install; the two never coincide in practice.
   for (genvar gi = 0; gi < NUM_LINES; gi++) begin : g_valid
      logic r_v;
      always_ff @(posedge clk) begin
         if (reset || i_flush_all) begin
            r_v <= 1'b0;
         end else if (i_install && (i_install_idx == IDX_W'(gi))) begin
            r_v <= 1'b1;
         end
      end
      assign w_valid[gi] = r_v;
   end

   always_ff @(posedge clk) begin
      if (i_install) begin
         r_tag[i_install_idx] <= i_install_tag;
      end
   end

   assign o_hit = w_valid[i_lookup_idx] && (r_tag[i_lookup_idx] == i_lookup_tag);
endmodule

// File: rtl/i_cache.sv
// Direct-mapped read-only instruction cache: zero-latency hits, whole-line
// refill on a miss, flush of all lines, and hit/miss performance counters.
module i_cache
   import i_cache_pkg::*;
#(
   parameter int WORD_SIZE  = IC_WORD_SIZE,
   parameter int LINE_WORDS = IC_LINE_WORDS,
   parameter int NUM_LINES  = IC_NUM_LINES
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            c_readM,
   input  logic [WORD_SIZE-1:0]            c_address,
   output logic [WORD_SIZE-1:0]            c_data,
   output logic                            c_ready,
   input  logic                            flush,
   output logic                            m_readM,
   output logic [WORD_SIZE-1:0]            m_address,
   input  logic [WORD_SIZE*LINE_WORDS-1:0] m_line,
   input  logic                            m_valid,
   output logic [WORD_SIZE-1:0]            num_hits,
   output logic [WORD_SIZE-1:0]            num_misses
);
   localparam int OFS_W = $clog2(LINE_WORDS);
   localparam int IDX_W = $clog2(NUM_LINES);
   localparam int TAG_W = WORD_SIZE - IDX_W - OFS_W;

   ic_state_e                             r_state;
   logic [WORD_SIZE-1:0]                  r_miss_addr;
   logic [WORD_SIZE-1:0]                  r_m_address;
   logic                                  r_m_readM;
   logic                                  r_flush_pending;
   logic [WORD_SIZE-1:0]                  r_num_hits;
   logic [WORD_SIZE-1:0]                  r_num_misses;
   logic [LINE_WORDS-1:0][WORD_SIZE-1:0]  r_data [NUM_LINES];
   logic [LINE_WORDS-1:0][WORD_SIZE-1:0]  r_resp_line;

   logic [TAG_W-1:0] w_tag, w_miss_tag;
   logic [IDX_W-1:0] w_idx, w_miss_idx;
   logic [OFS_W-1:0] w_ofs, w_miss_ofs;
   logic             w_hit;
   logic             w_fill_done;
   logic             w_flush_all;

   assign w_tag      = c_address[WORD_SIZE-1 -: TAG_W];
   assign w_idx      = c_address[OFS_W +: IDX_W];
   assign w_ofs      = c_address[OFS_W-1:0];
   assign w_miss_tag = r_miss_addr[WORD_SIZE-1 -: TAG_W];
   assign w_miss_idx = r_miss_addr[OFS_W +: IDX_W];
   assign w_miss_ofs = r_miss_addr[OFS_W-1:0];

   assign w_fill_done = (r_state == IC_FILL) && m_valid && !reset;
   // A flush seen during a fill is deferred until the RESP->IDLE transition,
   // so the freshly installed line is invalidated as well.
   assign w_flush_all = ((r_state == IC_IDLE) && flush) ||
                        ((r_state == IC_RESP) && (flush || r_flush_pending));

   ic_tag_store #(
      .NUM_LINES (NUM_LINES),
      .IDX_W     (IDX_W),
      .TAG_W     (TAG_W)
   ) u_tag_store (
      .clk           (clk),
      .reset         (reset),
      .i_lookup_idx  (w_idx),
      .i_lookup_tag  (w_tag),
      .o_hit         (w_hit),
      .i_install     (w_fill_done),
      .i_install_idx (w_miss_idx),
      .i_install_tag (w_miss_tag),
      .i_flush_all   (w_flush_all)
   );

   always_ff @(posedge clk) begin
      if (w_fill_done) begin
         r_data[w_miss_idx] <= m_line;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state         <= IC_IDLE;
         r_m_readM       <= 1'b0;
         r_m_address     <= '0;
         r_num_hits      <= '0;
         r_num_misses    <= '0;
         r_flush_pending <= 1'b0;
      end else begin
         case (r_state)
            IC_IDLE: begin
               if (c_readM && w_hit) begin
                  r_num_hits <= r_num_hits + WORD_SIZE'(1);
               end else if (c_readM) begin
                  r_miss_addr  <= c_address;
                  r_m_address  <= {c_address[WORD_SIZE-1:OFS_W], {OFS_W{1'b0}}};
                  r_m_readM    <= 1'b1;
                  r_num_misses <= r_num_misses + WORD_SIZE'(1);
                  r_state      <= IC_FILL;
               end
            end
            IC_FILL: begin
               if (flush) begin
                  r_flush_pending <= 1'b1;
               end
               if (m_valid) begin
                  r_resp_line <= m_line;
                  r_m_readM   <= 1'b0;
                  r_state     <= IC_RESP;
               end
            end
            IC_RESP: begin
               r_flush_pending <= 1'b0;
               r_state         <= IC_IDLE;
            end
            default: begin
               r_state <= IC_IDLE;
            end
         endcase
      end
   end

   // Hits are served straight from the array; RESP replays the captured line.
   always_comb begin
      c_ready = 1'b0;
      c_data  = r_data[w_idx][w_ofs];
      case (r_state)
         IC_IDLE: c_ready = c_readM && w_hit;
         IC_RESP: begin
            c_ready = c_readM && (c_address == r_miss_addr);
            c_data  = r_resp_line[w_miss_ofs];
         end
         default: c_ready = 1'b0;
      endcase
   end

   assign m_readM    = r_m_readM;
   assign m_address  = r_m_address;
   assign num_hits   = r_num_hits;
   assign num_misses = r_num_misses;
endmodule

// File: tb/tb_i_cache.sv
// Self-checking bench for i_cache: directed scenarios plus randomized accesses
// compared with a behavioural cache model held in the bench.
module tb_i_cache;
   logic        clk = 1'b0;
   logic        reset;
   logic        c_readM;
   logic [15:0] c_address;
   logic [15:0] c_data;
   logic        c_ready;
   logic        flush;
   logic        m_readM;
   logic [15:0] m_address;
   logic [63:0] m_line;
   logic        m_valid;
   logic [15:0] num_hits;
   logic [15:0] num_misses;

   int n_vec = 0;
   int n_err = 0;

   // Behavioural model: valid/tag per line plus hit/miss totals.
   bit          mv [8];
   logic [10:0] mt [8];
   int          m_hits;
   int          m_misses;

   i_cache dut (
      .clk        (clk),
      .reset      (reset),
      .c_readM    (c_readM),
      .c_address  (c_address),
      .c_data     (c_data),
      .c_ready    (c_ready),
      .flush      (flush),
      .m_readM    (m_readM),
      .m_address  (m_address),
      .m_line     (m_line),
      .m_valid    (m_valid),
      .num_hits   (num_hits),
      .num_misses (num_misses)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] mem_word(input logic [15:0] a);
      logic [15:0] p;
      p = a * 16'h2F1B;
      return p ^ 16'hC35A;
   endfunction

   function automatic logic [63:0] line_of(input logic [15:0] a);
      logic [63:0] l;
      for (int k = 0; k < 4; k++) l[k*16 +: 16] = mem_word({a[15:2], 2'(k)});
      return l;
   endfunction

   function automatic bit model_hit(input logic [15:0] a);
      return mv[a[4:2]] && (mt[a[4:2]] == a[15:5]);
   endfunction

   task automatic model_install(input logic [15:0] a);
      mv[a[4:2]] = 1'b1;
      mt[a[4:2]] = a[15:5];
   endtask

   task automatic model_clear();
      for (int i = 0; i < 8; i++) mv[i] = 1'b0;
   endtask

   // One fetch; on a miss the bench plays memory with the given latency,
   // optionally pulsing flush in FILL cycle flush_cyc or dropping c_readM.
   task automatic access(input logic [15:0] addr, input int lat, input int flush_cyc,
                         input bit drop, output bit rdy0, output logic [15:0] dat0,
                         output bit req_ok, output bit resp_rdy,
                         output logic [15:0] resp_dat, output bit mreq_after);
      c_readM = 1'b1;
      c_address = addr;
      #4;
      rdy0 = c_ready;
      dat0 = c_data;
      req_ok = 1'b1;
      resp_rdy = 1'b0;
      resp_dat = '0;
      mreq_after = 1'b0;
      @(posedge clk); #1;
      if (!rdy0) begin
         if (drop) c_readM = 1'b0;
         for (int i = 0; i <= lat; i++) begin
            flush = (i == flush_cyc);
            if (i == lat) begin
               m_valid = 1'b1;
               m_line  = line_of(addr);
            end
            #4;
            if (m_readM !== 1'b1 || m_address !== {addr[15:2], 2'b00}) req_ok = 1'b0;
            @(posedge clk); #1;
         end
         flush = 1'b0;
         m_valid = 1'b0;
         #4;
         resp_rdy = c_ready;
         resp_dat = c_data;
         mreq_after = m_readM;
         @(posedge clk); #1;
      end
      c_readM = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #4;
      n_vec++;
      if (c_ready !== 1'b0 || m_readM !== 1'b0 || m_address !== 16'h0 ||
          num_hits !== 16'h0 || num_misses !== 16'h0) begin
         n_err++;
         $display("FAIL reset: ready=%b mreq=%b maddr=%h hits=%h misses=%h expected all zero",
                  c_ready, m_readM, m_address, num_hits, num_misses);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      model_clear();
      m_hits = 0;
      m_misses = 0;
   endtask

   task automatic test_first_miss();
      bit r0, ok, rr, ma;
      logic [15:0] d0, rd;
      access(16'h0005, 3, -1, 1'b0, r0, d0, ok, rr, rd, ma);
      model_install(16'h0005);
      m_misses++;
      n_vec++;
      if (r0 !== 1'b0 || ok !== 1'b1 || rr !== 1'b1 || rd !== mem_word(16'h0005) || ma !== 1'b0) begin
         n_err++;
         $display("FAIL first_miss: rdy0=%b req_ok=%b resp_rdy=%b resp_data=%h mreq=%b expected 0 1 1 %h 0",
                  r0, ok, rr, rd, ma, mem_word(16'h0005));
      end
      n_vec++;
      if (num_misses !== 16'd1) begin
         n_err++;
         $display("FAIL first_miss_count: num_misses=%0d expected 1", num_misses);
      end
   endtask

   task automatic test_hits();
      bit r0, ok, rr, ma;
      logic [15:0] d0, rd;
      logic [15:0] addrs [3] = '{16'h0004, 16'h0006, 16'h0007};
      for (int i = 0; i < 3; i++) begin
         access(addrs[i], 0, -1, 1'b0, r0, d0, ok, rr, rd, ma);
         m_hits++;
         n_vec++;
         if (r0 !== 1'b1 || d0 !== mem_word(addrs[i]) || m_readM !== 1'b0) begin
            n_err++;
            $display("FAIL hit_%h: ready=%b data=%h mreq=%b expected 1 %h 0",
                     addrs[i], r0, d0, m_readM, mem_word(addrs[i]));
         end
      end
      n_vec++;
      if (num_hits !== 16'd3) begin
         n_err++;
         $display("FAIL hit_count: num_hits=%0d expected 3", num_hits);
      end
   endtask

   task automatic test_conflict();
      bit r0, ok, rr, ma;
      logic [15:0] d0, rd;
      logic [15:0] addrs [2] = '{16'h0025, 16'h0005};
      for (int i = 0; i < 2; i++) begin
         access(addrs[i], 1, -1, 1'b0, r0, d0, ok, rr, rd, ma);
         model_install(addrs[i]);
         m_misses++;
         n_vec++;
         if (r0 !== 1'b0 || ok !== 1'b1 || rr !== 1'b1 || rd !== mem_word(addrs[i])) begin
            n_err++;
            $display("FAIL conflict_%h: rdy0=%b req_ok=%b resp_rdy=%b resp_data=%h expected 0 1 1 %h",
                     addrs[i], r0, ok, rr, rd, mem_word(addrs[i]));
         end
      end
      n_vec++;
      if (num_misses !== 16'd3) begin
         n_err++;
         $display("FAIL conflict_count: num_misses=%0d expected 3", num_misses);
      end
   endtask

   task automatic test_flush_mid_fill();
      bit r0, ok, rr, ma;
      logic [15:0] d0, rd;
      access(16'h0040, 2, 1, 1'b0, r0, d0, ok, rr, rd, ma);
      m_misses++;
      model_clear();
      n_vec++;
      if (r0 !== 1'b0 || rr !== 1'b1 || rd !== mem_word(16'h0040)) begin
         n_err++;
         $display("FAIL flush_fill_resp: rdy0=%b resp_rdy=%b resp_data=%h expected 0 1 %h",
                  r0, rr, rd, mem_word(16'h0040));
      end
      // 0x0005 was valid before the flush; it must now miss too.
      access(16'h0005, 0, -1, 1'b0, r0, d0, ok, rr, rd, ma);
      m_misses++;
      model_install(16'h0005);
      n_vec++;
      if (r0 !== 1'b0) begin
         n_err++;
         $display("FAIL flush_fill_old_line: ready=%b expected 0", r0);
      end
      access(16'h0040, 1, -1, 1'b0, r0, d0, ok, rr, rd, ma);
      m_misses++;
      model_install(16'h0040);
      n_vec++;
      if (r0 !== 1'b0 || rd !== mem_word(16'h0040)) begin
         n_err++;
         $display("FAIL flush_fill_reread: ready=%b resp_data=%h expected 0 %h",
                  r0, rd, mem_word(16'h0040));
      end
   endtask

   task automatic test_drop_during_fill();
      bit r0, ok, rr, ma;
      logic [15:0] d0, rd;
      access(16'h0013, 2, -1, 1'b1, r0, d0, ok, rr, rd, ma);
      m_misses++;
      model_install(16'h0013);
      n_vec++;
      if (r0 !== 1'b0 || ok !== 1'b1 || rr !== 1'b0) begin
         n_err++;
         $display("FAIL drop_fill: rdy0=%b req_ok=%b resp_rdy=%b expected 0 1 0", r0, ok, rr);
      end
      access(16'h0013, 0, -1, 1'b0, r0, d0, ok, rr, rd, ma);
      m_hits++;
      n_vec++;
      if (r0 !== 1'b1 || d0 !== mem_word(16'h0013) || m_readM !== 1'b0) begin
         n_err++;
         $display("FAIL drop_rehit: ready=%b data=%h mreq=%b expected 1 %h 0",
                  r0, d0, m_readM, mem_word(16'h0013));
      end
   endtask

   task automatic test_reset_mid_fill();
      bit r0, ok, rr, ma;
      logic [15:0] d0, rd;
      c_readM = 1'b1;
      c_address = 16'h0033;
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      c_readM = 1'b0;
      #4;
      n_vec++;
      if (m_readM !== 1'b0 || num_hits !== 16'h0 || num_misses !== 16'h0) begin
         n_err++;
         $display("FAIL reset_fill: mreq=%b hits=%0d misses=%0d expected 0 0 0",
                  m_readM, num_hits, num_misses);
      end
      model_clear();
      m_hits = 0;
      m_misses = 0;
      @(posedge clk); #1;
      m_valid = 1'b1;
      m_line = line_of(16'h0033);
      @(posedge clk); #1;
      m_valid = 1'b0;
      access(16'h0033, 1, -1, 1'b0, r0, d0, ok, rr, rd, ma);
      m_misses++;
      model_install(16'h0033);
      n_vec++;
      if (r0 !== 1'b0 || num_misses !== 16'd1) begin
         n_err++;
         $display("FAIL reset_fill_reread: ready=%b misses=%0d expected 0 1", r0, num_misses);
      end
   endtask

   task automatic test_idle_flush_same_cycle();
      bit r0, ok, rr, ma;
      logic [15:0] d0, rd;
      c_readM = 1'b1;
      c_address = 16'h0033;
      flush = 1'b1;
      #4;
      n_vec++;
      if (c_ready !== 1'b1 || c_data !== mem_word(16'h0033)) begin
         n_err++;
         $display("FAIL flush_same_cycle: ready=%b data=%h expected 1 %h",
                  c_ready, c_data, mem_word(16'h0033));
      end
      @(posedge clk); #1;
      flush = 1'b0;
      c_readM = 1'b0;
      m_hits++;
      model_clear();
      access(16'h0033, 0, -1, 1'b0, r0, d0, ok, rr, rd, ma);
      m_misses++;
      model_install(16'h0033);
      n_vec++;
      if (r0 !== 1'b0 || rr !== 1'b1) begin
         n_err++;
         $display("FAIL flush_after: rdy0=%b resp_rdy=%b expected 0 1", r0, rr);
      end
   endtask

   task automatic test_random();
      bit r0, ok, rr, ma, exp_hit, drop;
      logic [15:0] d0, rd, a;
      int lat;
      for (int n = 0; n < 80; n++) begin
         if ($urandom_range(0, 9) == 0) begin
            flush = 1'b1;
            @(posedge clk); #1;
            flush = 1'b0;
            model_clear();
            continue;
         end
         a = 16'($urandom_range(0, 95));
         lat = $urandom_range(0, 3);
         drop = ($urandom_range(0, 5) == 0);
         exp_hit = model_hit(a);
         access(a, lat, -1, drop, r0, d0, ok, rr, rd, ma);
         n_vec++;
         if (exp_hit) begin
            m_hits++;
            if (r0 !== 1'b1 || d0 !== mem_word(a)) begin
               n_err++;
               $display("FAIL rand_hit_%h: ready=%b data=%h expected 1 %h", a, r0, d0, mem_word(a));
            end
         end else begin
            m_misses++;
            model_install(a);
            if (r0 !== 1'b0 || ok !== 1'b1 || ma !== 1'b0 || rr !== !drop ||
                (!drop && rd !== mem_word(a))) begin
               n_err++;
               $display("FAIL rand_miss_%h: rdy0=%b req_ok=%b mreq=%b resp_rdy=%b resp_data=%h expected 0 1 0 %b %h",
                        a, r0, ok, ma, rr, rd, !drop, mem_word(a));
            end
         end
      end
      n_vec++;
      if (num_hits !== 16'(m_hits) || num_misses !== 16'(m_misses)) begin
         n_err++;
         $display("FAIL rand_counters: hits=%0d misses=%0d expected %0d %0d",
                  num_hits, num_misses, m_hits, m_misses);
      end
   endtask

   initial begin
      reset = 1'b1;
      c_readM = 1'b0;
      c_address = '0;
      flush = 1'b0;
      m_valid = 1'b0;
      m_line = '0;
      #1;
      test_reset();
      test_first_miss();
      test_hits();
      test_conflict();
      test_flush_mid_fill();
      test_drop_during_fill();
      test_reset_mid_fill();
      test_idle_flush_same_cycle();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
